// File: rtl/puf_rx_frame_assembler.sv
// Byte-to-frame assembler: packs REG_BIT_SIZE/8 UART bytes (first byte in the LSB) into one PUF command word.
// Optional build macro PUF_RX_CHKSUM_EN adds a trailing XOR checksum byte to every frame.

module puf_rx_frame_assembler #(
    parameter int REG_BIT_SIZE = 40,
    parameter int TIMEOUT_CYC  = 100000,
    localparam int NBYTES      = REG_BIT_SIZE / 8,
`ifdef PUF_RX_CHKSUM_EN
    localparam int FRAME_LEN   = NBYTES + 1,
`else
    localparam int FRAME_LEN   = NBYTES,
`endif
    localparam int CNT_W       = $clog2(FRAME_LEN + 1),
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_sft_rst,
    input  logic                    i_byte_valid,
    input  logic [7:0]              i_byte_data,
    input  logic                    i_dcod_ready,
    output logic                    o_rx_valid,
    output logic                    o_rx_ready,
    output logic                    o_rx_done,
    output logic [REG_BIT_SIZE-1:0] o_rx_data,
    output logic                    o_frame_err,
    output logic                    o_overrun,
    output logic [CNT_W-1:0]        o_byte_cnt
);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD, DONE} state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt_nx, cnt_inc;
    logic [TO_W-1:0]         to_cnt, to_nx, to_inc;
    logic [REG_BIT_SIZE-1:0] shift, shift_nx, byte_in, data_nx;
    logic                    done_nx, err_nx, ovr_nx, valid_nx, ready_nx;
`ifdef PUF_RX_CHKSUM_EN
    logic [7:0]              xor_acc, xor_nx;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = o_byte_cnt;
        to_nx    = to_cnt;
        shift_nx = shift;
        data_nx  = o_rx_data;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        ovr_nx   = o_overrun;
`ifdef PUF_RX_CHKSUM_EN
        xor_nx   = xor_acc;
`endif
        cnt_inc  = o_byte_cnt + CNT_W'(1);
        to_inc   = (to_cnt == TO_W'(TIMEOUT_CYC)) ? to_cnt : to_cnt + TO_W'(1);
        // Shifting right by a byte leaves arrival byte k at bits [8k+7:8k] once the frame is full.
        byte_in  = (REG_BIT_SIZE'(i_byte_data) << (REG_BIT_SIZE - 8)) | (shift >> 8);

        case (state)
            IDLE, COLLECT: begin
                if (i_byte_valid) begin
                    to_nx  = '0;
                    cnt_nx = cnt_inc;
`ifdef PUF_RX_CHKSUM_EN
                    if (o_byte_cnt == CNT_W'(NBYTES)) begin
                        if (i_byte_data == xor_acc) begin
                            state_nx = HOLD;
                        end else begin
                            state_nx = IDLE;
                            err_nx   = 1'b1;
                            cnt_nx   = '0;
                        end
                    end else begin
                        shift_nx = byte_in;
                        xor_nx   = (state == IDLE) ? i_byte_data : (xor_acc ^ i_byte_data);
                        state_nx = COLLECT;
                    end
`else
                    shift_nx = byte_in;
                    state_nx = (cnt_inc == CNT_W'(NBYTES)) ? HOLD : COLLECT;
`endif
                end else if (state == COLLECT) begin
                    to_nx = to_inc;
                    if (to_inc == TO_W'(TIMEOUT_CYC)) begin
                        state_nx = IDLE;
                        err_nx   = 1'b1;
                        cnt_nx   = '0;
                        to_nx    = '0;
                    end
                end
            end
            HOLD: begin
                if (i_byte_valid) begin
                    ovr_nx = 1'b1;
                end
                if (i_dcod_ready) begin
                    data_nx  = shift;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (i_byte_valid) begin
                    ovr_nx = 1'b1;
                end
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Soft reset flushes everything except the last delivered frame.
        if (i_sft_rst) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            to_nx    = '0;
            data_nx  = o_rx_data;
            done_nx  = 1'b0;
            err_nx   = 1'b0;
            ovr_nx   = 1'b0;
        end

        valid_nx = (state_nx == COLLECT) || (state_nx == HOLD);
        ready_nx = !i_sft_rst && (state_nx != DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            o_byte_cnt  <= '0;
            to_cnt      <= '0;
            shift       <= '0;
            o_rx_data   <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            o_rx_valid  <= 1'b0;
            o_rx_ready  <= 1'b0;
`ifdef PUF_RX_CHKSUM_EN
            xor_acc     <= '0;
`endif
        end else begin
            state       <= state_nx;
            o_byte_cnt  <= cnt_nx;
            to_cnt      <= to_nx;
            shift       <= shift_nx;
            o_rx_data   <= data_nx;
            o_rx_done   <= done_nx;
            o_frame_err <= err_nx;
            o_overrun   <= ovr_nx;
            o_rx_valid  <= valid_nx;
            o_rx_ready  <= ready_nx;
`ifdef PUF_RX_CHKSUM_EN
            xor_acc     <= xor_nx;
`endif
        end
    end

endmodule

// File: tb/tb_puf_rx_frame_assembler.sv
// Self-checking bench for puf_rx_frame_assembler: queue-based frame model compared every cycle,
// plus directed literal expectations; honours PUF_RX_CHKSUM_EN when defined.

module tb_puf_rx_frame_assembler;

    localparam int REG_BIT_SIZE = 40;
    localparam int TIMEOUT_CYC  = 16;
    localparam int NBYTES       = REG_BIT_SIZE / 8;
`ifdef PUF_RX_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int FRAME_LEN = NBYTES + (CHK ? 1 : 0);
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    localparam int SEL_DATA  = 0;
    localparam int SEL_DONE  = 1;
    localparam int SEL_ERR   = 2;
    localparam int SEL_VALID = 3;
    localparam int SEL_READY = 4;
    localparam int SEL_OVR   = 5;
    localparam int SEL_CNT   = 6;

    logic                    clk;
    logic                    rst;
    logic                    sft_rst;
    logic                    byte_valid;
    logic [7:0]              byte_data;
    logic                    dcod_ready;
    logic                    rx_valid;
    logic                    rx_ready;
    logic                    rx_done;
    logic [REG_BIT_SIZE-1:0] rx_data;
    logic                    frame_err;
    logic                    overrun;
    logic [CNT_W-1:0]        byte_cnt;

    int total;
    int bad;

    // Expected outputs produced by the model
    bit                      chk_en;
    bit                      e_valid, e_ready, e_done, e_err, e_ovr;
    logic [REG_BIT_SIZE-1:0] e_data;
    int                      e_cnt;

    // Model private state
    logic [7:0] q[$];
    bit         held;
    bit         in_done;
    int         idle;

    // Literal expectations posted by the stimulus, consumed by the compare process
    int               lit_sel[12];
    string            lit_name[12];
    logic [63:0]      lit_exp[12];
    int               lit_n;
    int               lit_seq;
    int               lit_seen;

    puf_rx_frame_assembler #(
        .REG_BIT_SIZE(REG_BIT_SIZE),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_sft_rst   (sft_rst),
        .i_byte_valid(byte_valid),
        .i_byte_data (byte_data),
        .i_dcod_ready(dcod_ready),
        .o_rx_valid  (rx_valid),
        .o_rx_ready  (rx_ready),
        .o_rx_done   (rx_done),
        .o_rx_data   (rx_data),
        .o_frame_err (frame_err),
        .o_overrun   (overrun),
        .o_byte_cnt  (byte_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit chk_ok();
        logic [7:0] x = 8'h00;
        for (int k = 0; k < NBYTES; k++) x ^= q[k];
        return x == q[NBYTES];
    endfunction

    // Frame model: a frame is the list of bytes received so far; it completes at FRAME_LEN bytes,
    // waits for the controller, then is delivered for one cycle.
    initial begin
        chk_en = 1'b0;
        held = 1'b0;
        in_done = 1'b0;
        idle = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                held = 1'b0; in_done = 1'b0; idle = 0;
                e_valid = 1'b0; e_ready = 1'b0; e_done = 1'b0; e_err = 1'b0; e_ovr = 1'b0;
                e_data = '0; e_cnt = 0;
                chk_en = 1'b1;
            end else if (sft_rst) begin
                q.delete();
                held = 1'b0; in_done = 1'b0; idle = 0;
                e_valid = 1'b0; e_ready = 1'b0; e_done = 1'b0; e_err = 1'b0; e_ovr = 1'b0;
                e_cnt = 0;
            end else begin
                e_done = 1'b0;
                e_err  = 1'b0;
                if (in_done) begin
                    if (byte_valid) e_ovr = 1'b1;
                    in_done = 1'b0;
                    q.delete();
                end else if (held) begin
                    if (byte_valid) e_ovr = 1'b1;
                    if (dcod_ready) begin
                        for (int k = 0; k < NBYTES; k++) e_data[8*k +: 8] = q[k];
                        held = 1'b0;
                        in_done = 1'b1;
                        e_done = 1'b1;
                    end
                end else if (byte_valid) begin
                    q.push_back(byte_data);
                    idle = 0;
                    if (q.size() == FRAME_LEN) begin
                        if (!CHK || chk_ok()) begin
                            held = 1'b1;
                        end else begin
                            e_err = 1'b1;
                            q.delete();
                        end
                    end
                end else if (q.size() != 0) begin
                    idle++;
                    if (idle == TIMEOUT_CYC) begin
                        e_err = 1'b1;
                        q.delete();
                        idle = 0;
                    end
                end
                e_cnt   = q.size();
                e_valid = (q.size() != 0) && !in_done;
                e_ready = !in_done;
            end
        end
    end

    function automatic logic [63:0] sample(input int sel);
        case (sel)
            SEL_DATA:  return 64'(rx_data);
            SEL_DONE:  return 64'(rx_done);
            SEL_ERR:   return 64'(frame_err);
            SEL_VALID: return 64'(rx_valid);
            SEL_READY: return 64'(rx_ready);
            SEL_OVR:   return 64'(overrun);
            SEL_CNT:   return 64'(byte_cnt);
            default:   return 64'h0;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT against model every cycle, then any literal expectations for this cycle.
    initial begin
        total = 0;
        bad = 0;
        lit_seen = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cmp("rx_valid",  64'(rx_valid),  64'(e_valid));
                cmp("rx_ready",  64'(rx_ready),  64'(e_ready));
                cmp("rx_done",   64'(rx_done),   64'(e_done));
                cmp("frame_err", 64'(frame_err), 64'(e_err));
                cmp("overrun",   64'(overrun),   64'(e_ovr));
                cmp("rx_data",   64'(rx_data),   64'(e_data));
                cmp("byte_cnt",  64'(byte_cnt),  64'(e_cnt));
                if (lit_seq != lit_seen) begin
                    for (int i = 0; i < lit_n; i++) cmp(lit_name[i], sample(lit_sel[i]), lit_exp[i]);
                    lit_seen = lit_seq;
                end
            end
        end
    end

    task automatic applyStimulus(input logic bv, input logic [7:0] bd, input logic rdy, input logic sr);
        @(posedge clk);
        #1;
        lit_n      = 0;
        byte_valid = bv;
        byte_data  = bd;
        dcod_ready = rdy;
        sft_rst    = sr;
    endtask

    task automatic checkOutput(input int sel, input string name, input logic [63:0] exp);
        lit_sel[lit_n]  = sel;
        lit_name[lit_n] = name;
        lit_exp[lit_n]  = exp;
        lit_n++;
        lit_seq++;
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic sendChecksum(input logic [7:0] c);
        if (CHK) applyStimulus(1'b1, c, 1'b0, 1'b0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        sft_rst = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        dcod_ready = 1'b0;
        lit_n = 0;
        lit_seq = 0;

        // Reset state
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_VALID, "rst_valid", 64'd0);
        checkOutput(SEL_READY, "rst_ready", 64'd0);
        checkOutput(SEL_DATA,  "rst_data",  64'd0);
        checkOutput(SEL_CNT,   "rst_cnt",   64'd0);
        checkOutput(SEL_OVR,   "rst_ovr",   64'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_READY, "idle_ready", 64'd1);
        checkOutput(SEL_VALID, "idle_valid", 64'd0);

        $display("[TB] test 1: spaced frame");
        sendByte(8'h21); applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_VALID, "t1_valid1", 64'd1);
        checkOutput(SEL_READY, "t1_ready1", 64'd1);
        checkOutput(SEL_CNT,   "t1_cnt1",   64'd1);
        idleCycles(8);
        sendByte(8'h43); applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_CNT, "t1_cnt2", 64'd2);
        idleCycles(8);
        sendByte(8'h10); idleCycles(9);
        sendByte(8'h00); idleCycles(9);
        sendByte(8'h00);
        sendChecksum(8'h72);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_CNT,   "t1_cnt_hold", 64'(FRAME_LEN));
        checkOutput(SEL_VALID, "t1_valid_hold", 64'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput(SEL_DONE, "t1_no_done_yet", 64'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_DONE,  "t1_done",  64'd1);
        checkOutput(SEL_DATA,  "t1_data",  64'h0000104321);
        checkOutput(SEL_VALID, "t1_valid_done", 64'd0);
        checkOutput(SEL_READY, "t1_ready_done", 64'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_DONE,  "t1_done_pulse", 64'd0);
        checkOutput(SEL_CNT,   "t1_cnt_idle",   64'd0);
        checkOutput(SEL_READY, "t1_ready_idle", 64'd1);

        $display("[TB] test 2: inter-byte timeout");
        sendByte(8'h11); sendByte(8'h22);
        idleCycles(15);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_ERR,   "t2_err_early", 64'd0);
        checkOutput(SEL_CNT,   "t2_cnt_wait",  64'd2);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_ERR,   "t2_err",   64'd1);
        checkOutput(SEL_CNT,   "t2_cnt",   64'd0);
        checkOutput(SEL_VALID, "t2_valid", 64'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_ERR, "t2_err_pulse", 64'd0);
        sendByte(8'hA1); sendByte(8'hB2); sendByte(8'hC3); sendByte(8'hD4); sendByte(8'hE5);
        sendChecksum(8'hE1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_DONE, "t2_done", 64'd1);
        checkOutput(SEL_DATA, "t2_data", 64'hE5D4C3B2A1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] test 3: overrun while held");
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04); sendByte(8'h05);
        sendChecksum(8'h01);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        checkOutput(SEL_OVR, "t3_ovr_before", 64'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_OVR, "t3_ovr", 64'd1);
        checkOutput(SEL_CNT, "t3_cnt", 64'(FRAME_LEN));
        idleCycles(3);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_DONE, "t3_done", 64'd1);
        checkOutput(SEL_DATA, "t3_data", 64'h0504030201);
        checkOutput(SEL_OVR,  "t3_ovr_sticky", 64'd1);
        idleCycles(2);
        checkOutput(SEL_OVR, "t3_ovr_later", 64'd1);

        $display("[TB] test 4: soft reset mid-frame");
        sendByte(8'h77); sendByte(8'h88); sendByte(8'h99);
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_CNT,   "t4_cnt",   64'd0);
        checkOutput(SEL_OVR,   "t4_ovr",   64'd0);
        checkOutput(SEL_DATA,  "t4_data",  64'h0504030201);
        checkOutput(SEL_VALID, "t4_valid", 64'd0);
        checkOutput(SEL_READY, "t4_ready", 64'd0);
        checkOutput(SEL_DONE,  "t4_done",  64'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_READY, "t4_ready_idle", 64'd1);
        checkOutput(SEL_CNT,   "t4_cnt_idle",   64'd0);

        $display("[TB] test 5: byte on the expiry cycle");
        sendByte(8'h5A);
        idleCycles(15);
        sendByte(8'h6B);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_ERR,   "t5_err",   64'd0);
        checkOutput(SEL_CNT,   "t5_cnt",   64'd2);
        checkOutput(SEL_VALID, "t5_valid", 64'd1);
        sendByte(8'h7C); sendByte(8'h8D); sendByte(8'h9E);
        sendChecksum(8'h5E);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_DONE, "t5_done", 64'd1);
        checkOutput(SEL_DATA, "t5_data", 64'h9E8D7C6B5A);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

`ifdef PUF_RX_CHKSUM_EN
        $display("[TB] test 6: checksum match and mismatch");
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04); sendByte(8'h05);
        sendByte(8'h01);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput(SEL_CNT,   "t6_cnt_hold", 64'd6);
        checkOutput(SEL_VALID, "t6_valid",    64'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_DONE, "t6_done", 64'd1);
        checkOutput(SEL_DATA, "t6_data", 64'h0504030201);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04); sendByte(8'h05);
        sendByte(8'h00);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput(SEL_ERR,   "t6_err",       64'd1);
        checkOutput(SEL_CNT,   "t6_cnt_err",   64'd0);
        checkOutput(SEL_VALID, "t6_valid_err", 64'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput(SEL_DONE, "t6_no_done", 64'd0);
        checkOutput(SEL_ERR,  "t6_err_pulse", 64'd0);
        idleCycles(3);
`endif

        idleCycles(2);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
